// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing constants and RGBI helpers.
// Used by the capture path and the sync generator.
package vga_timing_pkg;

    localparam int H_TOTAL    = 800;
    localparam int H_START    = 144;
    localparam int H_VISIBLE  = 640;
    localparam int V_START    = 35;
    localparam int V_VISIBLE  = 480;
    localparam int H_TOL      = 2;
    localparam int LOCK_LINES = 4;
    localparam int ADDR_W     = 19;
    localparam int V_CNT_W    = 10;

    localparam logic SYNC_POL = 1'b0;

    localparam int RGBI_RED     = 3;
    localparam int RGBI_GREEN   = 2;
    localparam int RGBI_BLUE    = 1;
    localparam int RGBI_INTENSE = 0;

    typedef enum logic {
        CAP_SEARCH,
        CAP_LOCKED
    } capState_t;

    function automatic logic [3:0] packRgbi(
        input logic r,
        input logic g,
        input logic b,
        input logic i
    );
        logic [3:0] p;
        p               = '0;
        p[RGBI_RED]     = r;
        p[RGBI_GREEN]   = g;
        p[RGBI_BLUE]    = b;
        p[RGBI_INTENSE] = i;
        return p;
    endfunction

endpackage

// File: rtl/vga_sync_sampler.sv
// Brings the external RGBI + sync lines into clk, normalises
// sync polarity and flags sync leading edges with matched colour.
module vga_sync_sampler
    import vga_timing_pkg::*;
#(
    parameter logic POL = 1'b0
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       redIn,
    input  logic       greenIn,
    input  logic       blueIn,
    input  logic       intenseIn,
    input  logic       hSyncIn,
    input  logic       vSyncIn,
    output logic       hEdge,
    output logic       vEdge,
    output logic [3:0] pix
);

    logic [5:0] meta;
    logic [5:0] sync;
    logic       hNorm;
    logic       vNorm;
    logic       hPrev;
    logic       vPrev;

    assign hNorm = sync[1] ^ ~POL;
    assign vNorm = sync[0] ^ ~POL;
    assign hEdge = hNorm & ~hPrev;
    assign vEdge = vNorm & ~vPrev;
    assign pix   = packRgbi(sync[5], sync[4], sync[3], sync[2]);

    // Two-flop synchronizer; prev starts high so the cleared
    // pipeline cannot fake a leading edge right after reset.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            meta  <= '0;
            sync  <= '0;
            hPrev <= 1'b1;
            vPrev <= 1'b1;
        end else begin
            meta  <= {redIn, greenIn, blueIn, intenseIn,
                      hSyncIn, vSyncIn};
            sync  <= meta;
            hPrev <= hNorm;
            vPrev <= vNorm;
        end
    end

endmodule

// File: rtl/vga_capture.sv
// RGBI video capture: recovers raster position, qualifies
// line timing and streams visible pixels to a framebuffer.
module vga_capture
    import vga_timing_pkg::*;
#(
    parameter int   H_TOTAL    = vga_timing_pkg::H_TOTAL,
    parameter int   H_START    = vga_timing_pkg::H_START,
    parameter int   H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
    parameter int   V_START    = vga_timing_pkg::V_START,
    parameter int   V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
    parameter int   H_TOL      = vga_timing_pkg::H_TOL,
    parameter int   LOCK_LINES = vga_timing_pkg::LOCK_LINES,
    parameter logic SYNC_POL   = vga_timing_pkg::SYNC_POL,
    parameter int   ADDR_W     = vga_timing_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              redIn,
    input  logic              greenIn,
    input  logic              blueIn,
    input  logic              intenseIn,
    input  logic              hSyncIn,
    input  logic              vSyncIn,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [3:0]        wrData,
    output logic              locked,
    output logic              frameDone
);

    localparam int HW = $clog2(2 * H_TOTAL);
    localparam int VW = V_CNT_W;
    localparam int GW = $clog2(LOCK_LINES + 1);

    localparam logic [HW-1:0] H_MAX  = HW'(2 * H_TOTAL - 1);
    localparam logic [HW-1:0] H_PRE  = HW'(2 * H_TOTAL - 2);
    localparam logic [HW-1:0] H_LO   = HW'(H_TOTAL - H_TOL - 1);
    localparam logic [HW-1:0] H_HI   = HW'(H_TOTAL + H_TOL - 1);
    localparam logic [HW-1:0] WIN_H0 = HW'(H_START);
    localparam logic [HW-1:0] WIN_H1 = HW'(H_START + H_VISIBLE);

    localparam logic [VW-1:0] V_MAX  = '1;
    localparam logic [VW-1:0] WIN_V0 = VW'(V_START);
    localparam logic [VW-1:0] WIN_V1 = VW'(V_START + V_VISIBLE);

    localparam logic [ADDR_W-1:0] LAST_ADDR =
        ADDR_W'(H_VISIBLE * V_VISIBLE - 1);
    localparam logic [GW-1:0] GOAL = GW'(LOCK_LINES - 1);

    logic              hEdge;
    logic              vEdge;
    logic [3:0]        pix;
    logic [HW-1:0]     hCountQ;
    logic [HW-1:0]     hPos;
    logic [VW-1:0]     vCountQ;
    logic [VW-1:0]     vPos;
    logic              seenEdge;
    logic              vPend;
    logic              frameValid;
    logic              timeout;
    logic              inTol;
    logic              lineGood;
    logic              lineBad;
    logic              frameStart;
    logic              inWin;
    logic [ADDR_W-1:0] addrCnt;
    logic [GW-1:0]     goodCnt;
    capState_t         state;

    vga_sync_sampler #(
        .POL(SYNC_POL)
    ) uSampler (
        .clk      (clk),
        .nRst     (nRst),
        .redIn    (redIn),
        .greenIn  (greenIn),
        .blueIn   (blueIn),
        .intenseIn(intenseIn),
        .hSyncIn  (hSyncIn),
        .vSyncIn  (vSyncIn),
        .hEdge    (hEdge),
        .vEdge    (vEdge),
        .pix      (pix)
    );

    // Position of the current sample and line-period verdict.
    always_comb begin
        hPos = hCountQ;
        if (hEdge)
            hPos = '0;
        else if (hCountQ != H_MAX)
            hPos = hCountQ + HW'(1);

        timeout = !hEdge && (hCountQ == H_PRE);
        inTol   = (hCountQ >= H_LO) && (hCountQ <= H_HI);
        lineGood = hEdge && seenEdge && inTol;
        lineBad  = (hEdge && seenEdge && !inTol) || timeout;

        frameStart = hEdge && (vPend || vEdge);
        vPos = vCountQ;
        if (frameStart)
            vPos = '0;
        else if (hEdge && vCountQ != V_MAX)
            vPos = vCountQ + VW'(1);

        inWin = (hPos >= WIN_H0) && (hPos < WIN_H1) &&
                (vPos >= WIN_V0) && (vPos < WIN_V1) &&
                locked && frameValid && !lineBad;
    end

    // Lock qualifier: LOCK_LINES good lines in a row to lock,
    // a single bad line drops it.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state   <= CAP_SEARCH;
            goodCnt <= '0;
            locked  <= 1'b0;
        end else begin
            unique case (state)
                CAP_SEARCH: begin
                    if (lineBad) begin
                        goodCnt <= '0;
                    end else if (lineGood) begin
                        if (goodCnt == GOAL) begin
                            state   <= CAP_LOCKED;
                            locked  <= 1'b1;
                            goodCnt <= '0;
                        end else begin
                            goodCnt <= goodCnt + GW'(1);
                        end
                    end
                end
                CAP_LOCKED: begin
                    if (lineBad) begin
                        state   <= CAP_SEARCH;
                        locked  <= 1'b0;
                        goodCnt <= '0;
                    end
                end
            endcase
        end
    end

    // Raster counters, frame gating and the write port.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            hCountQ    <= '0;
            vCountQ    <= '0;
            seenEdge   <= 1'b0;
            vPend      <= 1'b0;
            frameValid <= 1'b0;
            addrCnt    <= '0;
            wrEn       <= 1'b0;
            wrAddr     <= '0;
            wrData     <= '0;
            frameDone  <= 1'b0;
        end else begin
            hCountQ <= hPos;
            vCountQ <= vPos;
            if (hEdge)
                seenEdge <= 1'b1;

            if (frameStart)
                vPend <= 1'b0;
            else if (vEdge)
                vPend <= 1'b1;

            if (lineBad)
                frameValid <= 1'b0;
            else if (frameStart)
                frameValid <= locked;
            else if (inWin && addrCnt == LAST_ADDR)
                frameValid <= 1'b0;

            wrEn      <= inWin;
            frameDone <= wrEn && (wrAddr == LAST_ADDR);

            if (frameStart) begin
                addrCnt <= '0;
                wrAddr  <= '0;
            end else if (inWin) begin
                wrAddr  <= addrCnt;
                wrData  <= pix;
                addrCnt <= addrCnt + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced raster,
// with a queue of expected framebuffer writes.
module tb_vga_capture;

    localparam int TH  = 40;
    localparam int HS  = 6;
    localparam int HV  = 24;
    localparam int VS  = 2;
    localparam int VV  = 4;
    localparam int AW  = 19;
    localparam int LAST = HV * VV - 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    data;
    } exp_t;

    logic          clk = 1'b0;
    logic          nRst = 1'b0;
    logic          redIn = 1'b0;
    logic          greenIn = 1'b0;
    logic          blueIn = 1'b0;
    logic          intenseIn = 1'b0;
    logic          hSyncIn = 1'b1;
    logic          vSyncIn = 1'b1;
    logic          wrEn;
    logic [AW-1:0] wrAddr;
    logic [3:0]    wrData;
    logic          locked;
    logic          frameDone;

    int   checks = 0;
    int   errors = 0;
    int   wrCount = 0;
    int   fdCount = 0;
    bit   prevLast = 1'b0;
    exp_t q[$];
    exp_t e;

    vga_capture #(
        .H_TOTAL   (TH),
        .H_START   (HS),
        .H_VISIBLE (HV),
        .V_START   (VS),
        .V_VISIBLE (VV),
        .H_TOL     (2),
        .LOCK_LINES(4),
        .SYNC_POL  (1'b0),
        .ADDR_W    (AW)
    ) dut (
        .clk      (clk),
        .nRst     (nRst),
        .redIn    (redIn),
        .greenIn  (greenIn),
        .blueIn   (blueIn),
        .intenseIn(intenseIn),
        .hSyncIn  (hSyncIn),
        .vSyncIn  (vSyncIn),
        .wrEn     (wrEn),
        .wrAddr   (wrAddr),
        .wrData   (wrData),
        .locked   (locked),
        .frameDone(frameDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic driveSample(input bit hAct, input bit vAct,
                               input logic [3:0] c);
        @(negedge clk);
        hSyncIn = ~hAct;
        vSyncIn = ~vAct;
        {redIn, greenIn, blueIn, intenseIn} = c;
    endtask

    function automatic bit visible(input int x, input int y);
        return x >= HS && x < HS + HV && y >= VS && y < VS + VV;
    endfunction

    function automatic logic [3:0] colour(input int x, input int y);
        return 4'(x * 5 + y * 3 + 1);
    endfunction

    task automatic sendLine(input int period, input bit vs,
                            input bit cap, input int line,
                            input int probe);
        logic [3:0] c;
        for (int x = 0; x < period; x++) begin
            c = colour(x, line);
            driveSample(x < 4, vs, c);
            if (probe >= 0 && x == probe)
                chk("lockHold", 32'(locked), 32'd1);
            if (probe >= 0 && x == probe + 1)
                chk("lockDrop", 32'(locked), 32'd0);
            if (cap && visible(x, line))
                q.push_back('{addr: AW'((line - VS) * HV + x - HS),
                              data: c});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            driveSample(1'b0, 1'b0, 4'h0);
    endtask

    // Write monitor: every write must match the queue head.
    always @(negedge clk) begin
        if (frameDone === 1'b1) begin
            fdCount++;
            chk("doneAfterLast", 32'(prevLast), 32'd1);
        end
        prevLast = (wrEn === 1'b1) && (wrAddr == AW'(LAST));
        if (wrEn === 1'b1) begin
            wrCount++;
            if (q.size() == 0) begin
                chk("spuriousWr", 32'(wrAddr), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("wrAddr", 32'(wrAddr), 32'(e.addr));
                chk("wrData", 32'(wrData), 32'(e.data));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] c;

        // reset state
        idle(4);
        chk("rstWrEn", 32'(wrEn), 32'd0);
        chk("rstWrAddr", 32'(wrAddr), 32'd0);
        chk("rstWrData", 32'(wrData), 32'd0);
        chk("rstLocked", 32'(locked), 32'd0);
        chk("rstDone", 32'(frameDone), 32'd0);
        nRst = 1'b1;
        idle(6);

        // lock after four good line checks
        for (int l = 0; l < 4; l++)
            sendLine(TH, 1'b0, 1'b0, 0, -1);
        chk("notYetLocked", 32'(locked), 32'd0);
        sendLine(TH, 1'b0, 1'b0, 0, -1);
        chk("lockedAfter4", 32'(locked), 32'd1);

        // locked but no vSync yet: nothing written
        for (int l = 0; l < 3; l++)
            sendLine(TH, 1'b0, 1'b0, l, -1);
        chk("noVsyncWrites", 32'(wrCount), 32'd0);
        chk("noVsyncLocked", 32'(locked), 32'd1);

        // full frame
        sendLine(TH, 1'b1, 1'b1, 0, -1);
        for (int l = 1; l < VS + VV + 2; l++)
            sendLine(TH, 1'b0, 1'b1, l, -1);
        chk("frameWrites", 32'(wrCount), 32'(HV * VV));
        chk("frameDoneCnt", 32'(fdCount), 32'd1);
        chk("frameQueue", 32'(q.size()), 32'd0);

        // +/- 1 clock period keeps lock, no writes after frame
        sendLine(TH + 1, 1'b0, 1'b1, 20, -1);
        sendLine(TH - 1, 1'b0, 1'b1, 21, -1);
        sendLine(TH, 1'b0, 1'b1, 22, -1);
        chk("tolLocked", 32'(locked), 32'd1);
        chk("postFrameWrites", 32'(wrCount), 32'(HV * VV));

        // period +3 drops lock three samples after the edge
        sendLine(TH + 3, 1'b0, 1'b0, 0, -1);
        sendLine(TH, 1'b0, 1'b0, 0, 2);
        for (int l = 0; l < 4; l++)
            sendLine(TH, 1'b0, 1'b0, 0, -1);
        chk("relock1", 32'(locked), 32'd1);

        // missing hSync: lock drops at the saturating count
        sendLine(100, 1'b0, 1'b0, 0, 81);
        for (int l = 0; l < 5; l++)
            sendLine(TH, 1'b0, 1'b0, 0, -1);
        chk("relock2", 32'(locked), 32'd1);
        chk("timeoutWrites", 32'(wrCount), 32'(HV * VV));

        // reset in the middle of a visible line
        sendLine(TH, 1'b1, 1'b1, 0, -1);
        sendLine(TH, 1'b0, 1'b1, 1, -1);
        for (int x = 0; x < TH; x++) begin
            c = colour(x, VS);
            driveSample(x < 4, 1'b0, c);
            if (x >= HS && x <= 12)
                q.push_back('{addr: AW'(x - HS), data: c});
            if (x == 15)
                nRst = 1'b0;
            if (x >= 16 && x <= 18) begin
                chk("midRstWrEn", 32'(wrEn), 32'd0);
                chk("midRstLocked", 32'(locked), 32'd0);
                chk("midRstAddr", 32'(wrAddr), 32'd0);
                chk("midRstData", 32'(wrData), 32'd0);
            end
            if (x == 18)
                nRst = 1'b1;
        end
        chk("midRstQueue", 32'(q.size()), 32'd0);
        chk("midRstWrites", 32'(wrCount), 32'(HV * VV + 7));
        for (int l = 0; l < 4; l++)
            sendLine(TH, 1'b0, 1'b0, 0, -1);
        chk("rstNotLocked", 32'(locked), 32'd0);
        sendLine(TH, 1'b0, 1'b0, 0, -1);
        chk("rstRelocked", 32'(locked), 32'd1);
        chk("finalDoneCnt", 32'(fdCount), 32'd1);

        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive-side counterpart of the VGA output stage: samples an external 4-bit RGBI video stream plus hSync/vSync, one sample per clk.
- Recovers horizontal/vertical position, qualifies line timing (lock), and writes visible pixels to a framebuffer write port.
- Used for loopback self-test of the display controller and for capturing an external RGBI source.

Parameters:
- H_TOTAL, 800, clocks per line
- H_START, 144, clocks from hSync leading edge to first visible pixel
- H_VISIBLE, 640, visible pixels per line
- V_START, 35, lines from vSync leading edge to first visible line
- V_VISIBLE, 480, visible lines per frame
- H_TOL, 2, allowed ± deviation of measured line period, in clocks
- LOCK_LINES, 4, consecutive good lines required to lock
- SYNC_POL, 0, active level of hSyncIn/vSyncIn (0 = active-low)
- ADDR_W, 19, framebuffer address width

Ports:
- clk  in  1  system/pixel clock
- nRst  in  1  synchronous active-low reset
- redIn  in  1  external red, asynchronous
- greenIn  in  1  external green, asynchronous
- blueIn  in  1  external blue, asynchronous
- intenseIn  in  1  external intensity, asynchronous
- hSyncIn  in  1  external horizontal sync, asynchronous
- vSyncIn  in  1  external vertical sync, asynchronous
- wrEn  out  1  framebuffer write strobe
- wrAddr  out  ADDR_W  framebuffer address
- wrData  out  4  {red, green, blue, intense}
- locked  out  1  line timing qualified
- frameDone  out  1  one-cycle pulse after last pixel of a frame is written

Behaviour:
- Reset: synchronous; clk is the only clock; reset is sampled while nRst is low at a clk rising edge; all state clears. While in reset and afterwards until re-qualified: wrEn=0, wrAddr=0, wrData=0, locked=0, frameDone=0; FSM=SEARCH; counters=0; frameValid=0. Reset mid-frame aborts all writes immediately (next edge).
- Input conditioning: all six inputs pass through 2-flop synchronizers; syncs normalised to active-high (XOR with ~SYNC_POL). Leading edge = normalised sync 1 now, 0 previous cycle. Colour bits delayed identically so pixel/sync alignment is preserved.
- Horizontal: cycle of hSync leading edge E sets hCount=0; otherwise hCount increments, saturating at 2*H_TOTAL-1 (timeout).
- Line check at each E: period = previous hCount+1. Good if |period-H_TOTAL| <= H_TOL, else bad. Timeout reached counts as one bad line at the saturating cycle (does not repeat until next E). First E after reset only restarts hCount (no check).
- FSM SEARCH: goodCnt++ on good line, cleared on bad; goodCnt==LOCK_LINES -> LOCKED (locked=1 next cycle). LOCKED: any bad line -> SEARCH, locked=0, goodCnt=0, frameValid=0, any in-progress line writes stop that cycle.
- Vertical: vSync leading edge sets vPend. At next E: if vPend, vCount=0, wrAddr=0, vPend=0, and frameValid=locked; else vCount++ saturating at 1023. vSync and hSync edges in same cycle: vPend set and consumed in that cycle.
- Capture window: sample with H_START <= hCount < H_START+H_VISIBLE and V_START <= vCount < V_START+V_VISIBLE, locked=1, frameValid=1.
- Write: registered; 1 cycle after in-window sample, wrEn=1, wrData=sample, wrAddr = current address; address then increments by 1 (no multiplier). Pixel (x,y) lands at y*H_VISIBLE+x.
- frameDone: asserted the cycle after the write of address H_VISIBLE*V_VISIBLE-1; frameValid then clears until the next vSync.
- No write when out of window; wrData holds last value, wrEn=0.
- Widths: hCount wide enough for 2*H_TOTAL; vCount 10 bits; address wrap impossible by window limits.

Decomposition:
- Shared package vga_timing_pkg: 640x480 timing constants (H_TOTAL, H_START, V_START, etc.), RGBI bit-order constants; shared with the sync generator.
- Sub-module vga_sync_sampler: 2-flop synchronizer, polarity normalise, leading-edge detect for hSync/vSync plus matched colour delay.

Test Plan:
- Reset: nRst low 3 cycles during active video -> all outputs 0 next edge, locked=0 until 4 good lines after release.
- Lock: 5 lines of period 800 -> locked rises after 4th good check; period 801/799 keeps lock; period 803 -> locked=0 next cycle, writes stop.
- Missing hSync: stop hSync after lock -> locked=0 at hCount=1599, no further wrEn.
- Full frame: locked, vSync edge then 525 lines with pixel = x[3:0] -> 307200 writes, addr 0..307199 in order, wrData correct, one frameDone after final write.
- Alignment: single white pixel at x=0,y=0 and x=639,y=479 -> written at addr 0 and 307199; no write for hCount=143 or 784.
- No vSync since lock: lines arrive, locked=1 -> zero writes until vSync edge seen.
